// File: rtl/vending_inventory_if.sv
// Request/response bundle between the vending controller and its user side,
// including the product record bus sampled by the stock-file writer.
interface vending_inventory_if;
  logic        sel_valid;
  logic [2:0]  sel_id;
  logic        coin_valid;
  logic [3:0]  coin_value;
  logic        cancel;
  logic        restock_valid;
  logic [2:0]  restock_id;
  logic [3:0]  restock_count;
  logic [10:0] p0;
  logic [10:0] p1;
  logic [10:0] p2;
  logic [10:0] p3;
  logic [10:0] p4;
  logic        busy;
  logic        dispense_valid;
  logic [2:0]  dispense_id;
  logic        change_valid;
  logic [4:0]  change_amount;
  logic        coin_reject;
  logic        err;

  modport slave (
    input  sel_valid, sel_id, coin_valid, coin_value, cancel,
           restock_valid, restock_id, restock_count,
    output p0, p1, p2, p3, p4, busy, dispense_valid, dispense_id,
           change_valid, change_amount, coin_reject, err
  );

  modport master (
    output sel_valid, sel_id, coin_valid, coin_value, cancel,
           restock_valid, restock_id, restock_count,
    input  p0, p1, p2, p3, p4, busy, dispense_valid, dispense_id,
           change_valid, change_amount, coin_reject, err
  );
endinterface

// File: rtl/vending_inventory.sv
// Inventory and transaction controller: five product records plus the
// select / pay / dispense / change sequence.
module vending_inventory #(
  parameter logic [3:0] INIT_COUNT = 4'd5,
  parameter logic [3:0] PRICE0     = 4'd3,
  parameter logic [3:0] PRICE1     = 4'd5,
  parameter logic [3:0] PRICE2     = 4'd7,
  parameter logic [3:0] PRICE3     = 4'd9,
  parameter logic [3:0] PRICE4     = 4'd12,
  parameter logic [3:0] TIMEOUT    = 4'd15
) (
  input logic                 clock,
  input logic                 reset_n,
  vending_inventory_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    COLLECT  = 2'd1,
    DISPENSE = 2'd2,
    REFUND   = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  sel_q, sel_d;
  logic [4:0]  credit_q, credit_d;
  logic [3:0]  timer_q, timer_d;
  logic [3:0]  count_q [5];
  logic [3:0]  count_d [5];
  logic        coin_reject_q, coin_reject_d;
  logic        err_q, err_d;

  logic [5:0]  coin_sum;
  logic [4:0]  timer_inc;
  logic [3:0]  sel_price;
  logic        dispensing;
  logic        timed_out;

  function automatic logic [3:0] price_of(input logic [2:0] id);
    case (id)
      3'd0:    price_of = PRICE0;
      3'd1:    price_of = PRICE1;
      3'd2:    price_of = PRICE2;
      3'd3:    price_of = PRICE3;
      default: price_of = PRICE4;
    endcase
  endfunction

  // Restock sum is formed one bit wider so the saturation to 15 is exact.
  function automatic logic [3:0] sat_add(input logic [3:0] a, input logic [3:0] b);
    logic [4:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    sat_add = sum[4] ? 4'd15 : sum[3:0];
  endfunction

  always_comb begin
    state_d       = state_q;
    sel_d         = sel_q;
    credit_d      = credit_q;
    timer_d       = timer_q;
    coin_reject_d = 1'b0;
    err_d         = 1'b0;
    dispensing    = 1'b0;
    timed_out     = 1'b0;
    coin_sum      = {1'b0, credit_q} + {2'b00, bus.coin_value};
    timer_inc     = {1'b0, timer_q} + 5'd1;
    sel_price     = price_of(sel_q);

    case (state_q)
      IDLE: begin
        if (bus.coin_valid) coin_reject_d = 1'b1;
        if (bus.sel_valid) begin
          if (bus.sel_id > 3'd4) begin
            err_d = 1'b1;
          end else if (count_q[bus.sel_id] == 4'd0) begin
            err_d = 1'b1;
          end else begin
            sel_d    = bus.sel_id;
            credit_d = 5'd0;
            timer_d  = 4'd0;
            state_d  = COLLECT;
          end
        end
      end
      COLLECT: begin
        if (bus.cancel) begin
          if (bus.coin_valid) coin_reject_d = 1'b1;
          timer_d = 4'd0;
          state_d = (credit_q == 5'd0) ? IDLE : REFUND;
        end else begin
          if (bus.coin_valid && coin_sum <= 6'd31) begin
            credit_d = coin_sum[4:0];
            timer_d  = 4'd0;
          end else begin
            if (bus.coin_valid) coin_reject_d = 1'b1;
            timer_d   = timer_inc[3:0];
            timed_out = (timer_inc == {1'b0, TIMEOUT});
          end
          // Payment decision uses the registered credit, one cycle behind the coin.
          if (credit_q >= {1'b0, sel_price}) begin
            state_d = DISPENSE;
          end else if (timed_out) begin
            state_d = (credit_q == 5'd0) ? IDLE : REFUND;
          end
        end
      end
      DISPENSE: begin
        if (bus.coin_valid) coin_reject_d = 1'b1;
        dispensing = 1'b1;
        credit_d   = credit_q - {1'b0, sel_price};
        state_d    = (credit_d != 5'd0) ? REFUND : IDLE;
      end
      default: begin
        if (bus.coin_valid) coin_reject_d = 1'b1;
        credit_d = 5'd0;
        state_d  = IDLE;
      end
    endcase

    // A dispense and a restock of the same product on one edge both apply.
    for (int i = 0; i < 5; i++) begin
      logic [3:0] base;
      base = count_q[i];
      if (dispensing && sel_q == i[2:0]) base = base - 4'd1;
      if (bus.restock_valid && bus.restock_id == i[2:0])
        count_d[i] = sat_add(base, bus.restock_count);
      else
        count_d[i] = base;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      sel_q         <= 3'd0;
      credit_q      <= 5'd0;
      timer_q       <= 4'd0;
      coin_reject_q <= 1'b0;
      err_q         <= 1'b0;
      for (int i = 0; i < 5; i++) count_q[i] <= INIT_COUNT;
    end else begin
      state_q       <= state_d;
      sel_q         <= sel_d;
      credit_q      <= credit_d;
      timer_q       <= timer_d;
      coin_reject_q <= coin_reject_d;
      err_q         <= err_d;
      for (int i = 0; i < 5; i++) count_q[i] <= count_d[i];
    end
  end

  assign bus.busy           = (state_q != IDLE);
  assign bus.dispense_valid = (state_q == DISPENSE);
  assign bus.dispense_id    = (state_q == DISPENSE) ? sel_q : 3'd0;
  assign bus.change_valid   = (state_q == REFUND);
  assign bus.change_amount  = (state_q == REFUND) ? credit_q : 5'd0;
  assign bus.coin_reject    = coin_reject_q;
  assign bus.err            = err_q;

  assign bus.p0 = {3'd0, count_q[0], PRICE0};
  assign bus.p1 = {3'd1, count_q[1], PRICE1};
  assign bus.p2 = {3'd2, count_q[2], PRICE2};
  assign bus.p3 = {3'd3, count_q[3], PRICE3};
  assign bus.p4 = {3'd4, count_q[4], PRICE4};

endmodule

// File: tb/tb_vending_inventory.sv
// Directed bench for vending_inventory: a vector table for the main flows and
// hand-written sequences for drain, credit overflow, timeout and async reset.
module tb_vending_inventory;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  int   n_checks = 0;
  int   n_err = 0;

  vending_inventory_if vif();

  vending_inventory dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (vif.slave)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic       sv;  logic [2:0] sid;
    logic       cv;  logic [3:0] cval;
    logic       can;
    logic       rv;  logic [2:0] rid; logic [3:0] rc;
    logic       busy;
    logic       dv;  logic [2:0] did;
    logic       chv; logic [4:0] camt;
    logic       rej; logic       err;
    int         pidx; logic [3:0] pcnt;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string nm, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic logic [10:0] rec(input int idx);
    case (idx)
      0:       rec = vif.p0;
      1:       rec = vif.p1;
      2:       rec = vif.p2;
      3:       rec = vif.p3;
      default: rec = vif.p4;
    endcase
  endfunction

  task automatic drive(input logic sv, input logic [2:0] sid, input logic cv,
                       input logic [3:0] cval, input logic can, input logic rv,
                       input logic [2:0] rid, input logic [3:0] rc);
    vif.sel_valid     = sv;
    vif.sel_id        = sid;
    vif.coin_valid    = cv;
    vif.coin_value    = cval;
    vif.cancel        = can;
    vif.restock_valid = rv;
    vif.restock_id    = rid;
    vif.restock_count = rc;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    tick();
  endtask

  task automatic add(input logic sv, input logic [2:0] sid, input logic cv,
                     input logic [3:0] cval, input logic can, input logic rv,
                     input logic [2:0] rid, input logic [3:0] rc,
                     input logic busy, input logic dv, input logic [2:0] did,
                     input logic chv, input logic [4:0] camt, input logic rej,
                     input logic err, input int pidx, input logic [3:0] pcnt);
    vec_t v;
    v.sv = sv; v.sid = sid; v.cv = cv; v.cval = cval; v.can = can;
    v.rv = rv; v.rid = rid; v.rc = rc;
    v.busy = busy; v.dv = dv; v.did = did; v.chv = chv; v.camt = camt;
    v.rej = rej; v.err = err; v.pidx = pidx; v.pcnt = pcnt;
    vecs.push_back(v);
  endtask

  task automatic check_strobes_quiet(input string tag);
    check({tag, "_dispense_valid"}, int'(vif.dispense_valid), 0);
    check({tag, "_change_valid"}, int'(vif.change_valid), 0);
    check({tag, "_busy"}, int'(vif.busy), 0);
  endtask

  initial begin
    logic [10:0] r;
    drive(0, 0, 0, 0, 0, 0, 0, 0);

    // Reset state
    repeat (2) @(posedge clock);
    #1;
    reset_n = 1'b1;
    check("reset_p0", int'(vif.p0), int'(11'b000_0101_0011));
    check("reset_p4", int'(vif.p4), int'({3'd4, 4'd5, 4'd12}));
    check("reset_p2", int'(vif.p2), int'({3'd2, 4'd5, 4'd7}));
    check_strobes_quiet("reset");
    check("reset_coin_reject", int'(vif.coin_reject), 0);
    check("reset_err", int'(vif.err), 0);
    check("reset_change_amount", int'(vif.change_amount), 0);
    check("reset_dispense_id", int'(vif.dispense_id), 0);

    //   sv sid cv cv  can rv rid rc | busy dv did chv camt rej err | p cnt
    // exact pay on product 1 (price 5)
    add(1, 1, 0, 0, 0, 0, 0, 0,   1, 0, 0, 0, 0, 0, 0,   1, 5);
    add(0, 0, 1, 5, 0, 0, 0, 0,   1, 0, 0, 0, 0, 0, 0,   1, 5);
    add(0, 0, 0, 0, 0, 0, 0, 0,   1, 1, 1, 0, 0, 0, 0,   1, 5);
    add(0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0,   1, 4);
    // overpay on product 0 (price 3): coins 2 then 4, change 3
    add(1, 0, 0, 0, 0, 0, 0, 0,   1, 0, 0, 0, 0, 0, 0,   0, 5);
    add(0, 0, 1, 2, 0, 0, 0, 0,   1, 0, 0, 0, 0, 0, 0,   0, 5);
    add(0, 0, 1, 4, 0, 0, 0, 0,   1, 0, 0, 0, 0, 0, 0,   0, 5);
    add(0, 0, 0, 0, 0, 0, 0, 0,   1, 1, 0, 0, 0, 0, 0,   0, 5);
    add(0, 0, 0, 0, 0, 0, 0, 0,   1, 0, 0, 1, 3, 0, 0,   0, 4);
    add(0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0,   0, 4);
    // invalid id, coin while idle
    add(1, 6, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 1,   0, 4);
    add(0, 0, 1, 3, 0, 0, 0, 0,   0, 0, 0, 0, 0, 1, 0,   0, 4);
    add(0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0,   0, 4);
    // cancel on product 3 after coin 4; coin alongside cancel is rejected
    add(1, 3, 0, 0, 0, 0, 0, 0,   1, 0, 0, 0, 0, 0, 0,   3, 5);
    add(0, 0, 1, 4, 0, 0, 0, 0,   1, 0, 0, 0, 0, 0, 0,   3, 5);
    add(0, 0, 1, 2, 1, 0, 0, 0,   1, 0, 0, 1, 4, 1, 0,   3, 5);
    add(0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0,   3, 5);
    // restock saturation and out-of-range restock id
    add(0, 0, 0, 0, 0, 1, 4, 12,  0, 0, 0, 0, 0, 0, 0,   4, 15);
    add(0, 0, 0, 0, 0, 1, 7, 3,   0, 0, 0, 0, 0, 0, 0,   4, 15);
    // dispense of product 1 coinciding with restock of product 1 by 2: 4-1+2
    add(1, 1, 0, 0, 0, 0, 0, 0,   1, 0, 0, 0, 0, 0, 0,   1, 4);
    add(0, 0, 1, 5, 0, 0, 0, 0,   1, 0, 0, 0, 0, 0, 0,   1, 4);
    add(0, 0, 0, 0, 0, 0, 0, 0,   1, 1, 1, 0, 0, 0, 0,   1, 4);
    add(0, 0, 0, 0, 0, 1, 1, 2,   0, 0, 0, 0, 0, 0, 0,   1, 5);

    foreach (vecs[k]) begin
      drive(vecs[k].sv, vecs[k].sid, vecs[k].cv, vecs[k].cval, vecs[k].can,
            vecs[k].rv, vecs[k].rid, vecs[k].rc);
      tick();
      check($sformatf("v%0d_busy", k), int'(vif.busy), int'(vecs[k].busy));
      check($sformatf("v%0d_dispense_valid", k), int'(vif.dispense_valid), int'(vecs[k].dv));
      check($sformatf("v%0d_dispense_id", k), int'(vif.dispense_id), int'(vecs[k].did));
      check($sformatf("v%0d_change_valid", k), int'(vif.change_valid), int'(vecs[k].chv));
      check($sformatf("v%0d_change_amount", k), int'(vif.change_amount), int'(vecs[k].camt));
      check($sformatf("v%0d_coin_reject", k), int'(vif.coin_reject), int'(vecs[k].rej));
      check($sformatf("v%0d_err", k), int'(vif.err), int'(vecs[k].err));
      r = rec(vecs[k].pidx);
      check($sformatf("v%0d_count_p%0d", k, vecs[k].pidx), int'(r[7:4]), int'(vecs[k].pcnt));
    end
    check("p1_full_record", int'(vif.p1), int'({3'd1, 4'd5, 4'd5}));
    check("p3_full_record", int'(vif.p3), int'({3'd3, 4'd5, 4'd9}));

    // Drain product 2 (price 7) with five exact purchases, then select it again
    for (int n = 0; n < 5; n++) begin
      drive(1, 2, 0, 0, 0, 0, 0, 0); tick();
      drive(0, 0, 1, 7, 0, 0, 0, 0); tick();
      idle_tick();
      check($sformatf("drain%0d_dispense_id", n), int'(vif.dispense_id), 2);
      idle_tick();
      check($sformatf("drain%0d_busy", n), int'(vif.busy), 0);
    end
    r = rec(2);
    check("drain_count_p2", int'(r[7:4]), 0);
    drive(1, 2, 0, 0, 0, 0, 0, 0); tick();
    check("soldout_err", int'(vif.err), 1);
    check("soldout_busy", int'(vif.busy), 0);
    idle_tick();
    check("soldout_err_pulse", int'(vif.err), 0);

    // Credit 26 plus coin 15 overflows: rejected, credit kept, change 14
    drive(1, 4, 0, 0, 0, 0, 0, 0); tick();
    drive(0, 0, 1, 11, 0, 0, 0, 0); tick();
    drive(0, 0, 1, 15, 0, 0, 0, 0); tick();
    check("ovf_accept26_reject", int'(vif.coin_reject), 0);
    check("ovf_accept26_busy", int'(vif.busy), 1);
    drive(0, 0, 1, 15, 0, 0, 0, 0); tick();
    check("ovf41_reject", int'(vif.coin_reject), 1);
    check("ovf41_dispense_id", int'(vif.dispense_id), 4);
    idle_tick();
    check("ovf41_change_valid", int'(vif.change_valid), 1);
    check("ovf41_change_amount", int'(vif.change_amount), 14);
    r = rec(4);
    check("ovf41_count_p4", int'(r[7:4]), 14);
    idle_tick();

    // Credit reaches 30 exactly (15+15 accepted); coin 5 afterwards is rejected
    drive(1, 4, 0, 0, 0, 0, 0, 0); tick();
    drive(0, 0, 1, 15, 0, 0, 0, 0); tick();
    drive(0, 0, 1, 15, 0, 0, 0, 0); tick();
    check("c30_reject", int'(vif.coin_reject), 0);
    check("c30_dispense_valid", int'(vif.dispense_valid), 1);
    drive(0, 0, 1, 5, 0, 0, 0, 0); tick();
    check("c30_plus5_reject", int'(vif.coin_reject), 1);
    check("c30_change_amount", int'(vif.change_amount), 18);
    idle_tick();
    check("c30_idle", int'(vif.busy), 0);

    // Timeout with no coins: back to IDLE on the 15th idle edge, no change
    drive(1, 3, 0, 0, 0, 0, 0, 0); tick();
    begin
      int chg_seen;
      chg_seen = 0;
      for (int t = 0; t < 14; t++) begin
        idle_tick();
        if (vif.change_valid) chg_seen++;
      end
      check("timeout_busy_before", int'(vif.busy), 1);
      idle_tick();
      if (vif.change_valid) chg_seen++;
      check("timeout_busy_after", int'(vif.busy), 0);
      check("timeout_no_change", chg_seen, 0);
    end
    r = rec(3);
    check("timeout_count_p3", int'(r[7:4]), 5);

    // Asynchronous reset in the middle of COLLECT
    drive(1, 0, 0, 0, 0, 0, 0, 0); tick();
    drive(0, 0, 1, 2, 0, 0, 0, 0); tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    #2;
    reset_n = 1'b0;
    #1;
    check_strobes_quiet("midreset");
    check("midreset_p0", int'(vif.p0), int'({3'd0, 4'd5, 4'd3}));
    check("midreset_p2", int'(vif.p2), int'({3'd2, 4'd5, 4'd7}));
    check("midreset_p4", int'(vif.p4), int'({3'd4, 4'd5, 4'd12}));
    tick();
    reset_n = 1'b1;
    begin
      int strobes;
      strobes = 0;
      for (int t = 0; t < 4; t++) begin
        idle_tick();
        if (vif.dispense_valid || vif.change_valid || vif.busy) strobes++;
      end
      check("postreset_quiet", strobes, 0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
